// File: rtl/renaming_pkg.sv
// Shared types and helpers for the multi-port register renaming stage.
package renaming_pkg;

  localparam int ARCH_W  = 5;
  localparam int PHYS_W  = 6;
  localparam int NR_ARCH = 2 ** ARCH_W;
  localparam int NR_PHYS = 2 ** PHYS_W;

  typedef logic [ARCH_W-1:0] arch_reg_t;
  typedef logic [PHYS_W-1:0] phys_reg_t;

  typedef struct packed {
    logic      valid;
    arch_reg_t rd;
    arch_reg_t rs1;
    arch_reg_t rs2;
  } rename_req_t;

  typedef struct packed {
    logic      valid;
    phys_reg_t prd;
    phys_reg_t prs1;
    phys_reg_t prs2;
    phys_reg_t old_prd;
  } rename_rsp_t;

  // Index of the lowest set bit; returns 0 when the vector is empty.
  function automatic phys_reg_t lowest_set(input logic [NR_PHYS-1:0] vec);
    phys_reg_t idx;
    idx = '0;
    for (int b = NR_PHYS - 1; b >= 0; b--) begin
      if (vec[b]) idx = phys_reg_t'(b);
    end
    return idx;
  endfunction

endpackage

// File: rtl/free_list_picker.sv
// Combinational free-register picker: one lowest-set-bit finder per port,
// each seeing the free vector with the earlier picks masked out, plus a
// popcount of the free vector.
module free_list_picker
  import renaming_pkg::*;
#(
  parameter int NR_PORTS = 2
) (
  input  logic [NR_PHYS-1:0]         free_vec,
  output logic [NR_PORTS*PHYS_W-1:0] pick_flat,
  output logic [PHYS_W:0]            free_count
);

  logic [NR_PORTS-1:0][NR_PHYS-1:0] mask;

  assign mask[0] = free_vec;

  generate
    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_pick
      phys_reg_t idx;
      assign idx = lowest_set(mask[gi]);
      assign pick_flat[gi*PHYS_W +: PHYS_W] = idx;
      if (gi + 1 < NR_PORTS) begin : g_next
        assign mask[gi+1] = mask[gi] & ~({{(NR_PHYS-1){1'b0}}, 1'b1} << idx);
      end
    end
  endgenerate

  // Count of free physical registers, used for the all-or-nothing ready.
  always_comb begin
    free_count = '0;
    for (int b = 0; b < NR_PHYS; b++) begin
      free_count = free_count + (PHYS_W+1)'(free_vec[b]);
    end
  end

endmodule

// File: rtl/renaming_map_mp.sv
// Multi-port register renaming: speculative map, retirement map and free
// vector. Renames a group of up to NR_PORTS instructions per cycle, retires
// up to NR_PORTS per cycle, and rebuilds speculative state on flush.
module renaming_map_mp
  import renaming_pkg::*;
#(
  parameter int ARCH_REG_WIDTH = ARCH_W,
  parameter int PHYS_REG_WIDTH = PHYS_W,
  parameter int NR_PORTS       = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NR_PORTS-1:0]                rename_valid_i,
  input  logic [NR_PORTS*ARCH_REG_WIDTH-1:0] rename_rd_i,
  input  logic [NR_PORTS*ARCH_REG_WIDTH-1:0] rename_rs1_i,
  input  logic [NR_PORTS*ARCH_REG_WIDTH-1:0] rename_rs2_i,
  output logic                               rename_ready_o,
  output logic [NR_PORTS-1:0]                issue_valid_o,
  output logic [NR_PORTS*PHYS_REG_WIDTH-1:0] issue_prd_o,
  output logic [NR_PORTS*PHYS_REG_WIDTH-1:0] issue_prs1_o,
  output logic [NR_PORTS*PHYS_REG_WIDTH-1:0] issue_prs2_o,
  output logic [NR_PORTS*PHYS_REG_WIDTH-1:0] issue_old_prd_o,
  input  logic [NR_PORTS-1:0]                commit_valid_i,
  input  logic [NR_PORTS*ARCH_REG_WIDTH-1:0] commit_ard_i,
  input  logic [NR_PORTS*PHYS_REG_WIDTH-1:0] commit_prd_i
);

  // Struct and table widths follow the package constants; the width
  // parameters are expected to keep their defaults.

  rename_req_t  req          [NR_PORTS];
  rename_rsp_t  rsp_comb     [NR_PORTS];
  rename_rsp_t  rsp_reg      [NR_PORTS];
  arch_reg_t    commit_ard   [NR_PORTS];
  phys_reg_t    commit_prd   [NR_PORTS];
  phys_reg_t    pick         [NR_PORTS];
  phys_reg_t    alloc_prd    [NR_PORTS];
  logic [NR_PORTS-1:0]        need;
  logic [NR_PORTS*PHYS_W-1:0] pick_flat;
  logic [PHYS_W:0]            free_count;
  logic [PHYS_W:0]            need_count;
  logic                       accept;

  phys_reg_t spec_map_reg    [NR_ARCH];
  phys_reg_t spec_map_next   [NR_ARCH];
  phys_reg_t retire_map_reg  [NR_ARCH];
  phys_reg_t retire_map_next [NR_ARCH];
  logic [NR_PHYS-1:0] free_reg;
  logic [NR_PHYS-1:0] free_next;
  logic [NR_PHYS-1:0] referenced;
  phys_reg_t          superseded;

  generate
    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
      assign req[gi] = {rename_valid_i[gi],
                        rename_rd_i[gi*ARCH_REG_WIDTH +: ARCH_REG_WIDTH],
                        rename_rs1_i[gi*ARCH_REG_WIDTH +: ARCH_REG_WIDTH],
                        rename_rs2_i[gi*ARCH_REG_WIDTH +: ARCH_REG_WIDTH]};
      // x0 never consumes a physical register.
      assign need[gi]       = req[gi].valid && (req[gi].rd != '0);
      assign pick[gi]       = pick_flat[gi*PHYS_W +: PHYS_W];
      assign commit_ard[gi] = commit_ard_i[gi*ARCH_REG_WIDTH +: ARCH_REG_WIDTH];
      assign commit_prd[gi] = commit_prd_i[gi*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];

      assign issue_valid_o[gi]                                     = rsp_reg[gi].valid;
      assign issue_prd_o[gi*PHYS_REG_WIDTH +: PHYS_REG_WIDTH]     = rsp_reg[gi].prd;
      assign issue_prs1_o[gi*PHYS_REG_WIDTH +: PHYS_REG_WIDTH]    = rsp_reg[gi].prs1;
      assign issue_prs2_o[gi*PHYS_REG_WIDTH +: PHYS_REG_WIDTH]    = rsp_reg[gi].prs2;
      assign issue_old_prd_o[gi*PHYS_REG_WIDTH +: PHYS_REG_WIDTH] = rsp_reg[gi].old_prd;

      // Retiring a register that is still on the free list means the
      // pipeline lost track of an allocation.
      a_commit_allocated : assert property (@(posedge clk_i) disable iff (rst_i)
        !(commit_valid_i[gi] && (commit_prd[gi] != '0) && free_reg[commit_prd[gi]]));
    end
  endgenerate

  free_list_picker #(
    .NR_PORTS (NR_PORTS)
  ) u_picker (
    .free_vec   (free_reg),
    .pick_flat  (pick_flat),
    .free_count (free_count)
  );

  // Number of ports in the group that need a fresh register.
  always_comb begin
    need_count = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      need_count = need_count + (PHYS_W+1)'(need[p]);
    end
  end

  // The group is taken whole or not at all; flush always refuses it.
  assign rename_ready_o = (free_count >= need_count) && !flush_i;
  assign accept         = rename_ready_o;

  // Hand out picks in port order, skipping ports that need none.
  always_comb begin
    int rank;
    rank = 0;
    for (int p = 0; p < NR_PORTS; p++) begin
      alloc_prd[p] = '0;
      if (need[p]) begin
        alloc_prd[p] = pick[rank];
        rank = rank + 1;
      end
    end
  end

  // Source and old-rd lookup with bypass from older ports of the same group.
  always_comb begin
    for (int j = 0; j < NR_PORTS; j++) begin
      rsp_comb[j].valid   = accept && req[j].valid;
      rsp_comb[j].prd     = alloc_prd[j];
      rsp_comb[j].prs1    = spec_map_reg[req[j].rs1];
      rsp_comb[j].prs2    = spec_map_reg[req[j].rs2];
      rsp_comb[j].old_prd = spec_map_reg[req[j].rd];
      // Ascending scan so the youngest older writer wins.
      for (int i = 0; i < j; i++) begin
        if (need[i]) begin
          if (req[i].rd == req[j].rs1) rsp_comb[j].prs1    = alloc_prd[i];
          if (req[i].rd == req[j].rs2) rsp_comb[j].prs2    = alloc_prd[i];
          if (req[i].rd == req[j].rd)  rsp_comb[j].old_prd = alloc_prd[i];
        end
      end
      if (req[j].rs1 == '0) rsp_comb[j].prs1 = '0;
      if (req[j].rs2 == '0) rsp_comb[j].prs2 = '0;
    end
  end

  // Retirement map and free vector: allocations, chained commits, flush rebuild.
  always_comb begin
    retire_map_next = retire_map_reg;
    free_next       = free_reg;
    referenced      = '0;
    superseded      = '0;
    if (accept) begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (need[p]) free_next[alloc_prd[p]] = 1'b0;
      end
    end
    // In order, so a younger commit to the same ard frees the older's prd.
    for (int c = 0; c < NR_PORTS; c++) begin
      if (commit_valid_i[c] && (commit_ard[c] != '0)) begin
        superseded                     = retire_map_next[commit_ard[c]];
        retire_map_next[commit_ard[c]] = commit_prd[c];
        if (superseded != '0) free_next[superseded] = 1'b1;
      end
    end
    if (flush_i) begin
      for (int a = 0; a < NR_ARCH; a++) begin
        referenced[retire_map_next[a]] = 1'b1;
      end
      free_next    = ~referenced;
      free_next[0] = 1'b0;
    end
  end

  // Speculative map: restored from the post-commit retire map on flush,
  // otherwise updated by the accepted group (youngest same-rd port last).
  always_comb begin
    spec_map_next = spec_map_reg;
    if (flush_i) begin
      spec_map_next = retire_map_next;
    end else if (accept) begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (need[p]) spec_map_next[req[p].rd] = alloc_prd[p];
      end
    end
  end

  // Map tables and free vector state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int a = 0; a < NR_ARCH; a++) begin
        spec_map_reg[a]   <= '0;
        retire_map_reg[a] <= '0;
      end
      free_reg <= {{(NR_PHYS-1){1'b1}}, 1'b0};
    end else begin
      spec_map_reg   <= spec_map_next;
      retire_map_reg <= retire_map_next;
      free_reg       <= free_next;
    end
  end

  // Registered issue outputs; indices hold when nothing is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NR_PORTS; p++) rsp_reg[p] <= '0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (accept) rsp_reg[p]       <= rsp_comb[p];
        else        rsp_reg[p].valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_renaming_map_mp.sv
// Scoreboard bench for renaming_map_mp: stimulus pushes expected renames per
// port, a negedge monitor pops and compares whenever issue_valid_o is high.
module tb_renaming_map_mp;

  localparam int AW = 5;
  localparam int PW = 6;
  localparam int NP = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic [NP-1:0]    rename_valid_i = '0;
  logic [NP*AW-1:0] rename_rd_i = '0;
  logic [NP*AW-1:0] rename_rs1_i = '0;
  logic [NP*AW-1:0] rename_rs2_i = '0;
  logic             rename_ready_o;
  logic [NP-1:0]    issue_valid_o;
  logic [NP*PW-1:0] issue_prd_o;
  logic [NP*PW-1:0] issue_prs1_o;
  logic [NP*PW-1:0] issue_prs2_o;
  logic [NP*PW-1:0] issue_old_prd_o;
  logic [NP-1:0]    commit_valid_i = '0;
  logic [NP*AW-1:0] commit_ard_i = '0;
  logic [NP*PW-1:0] commit_prd_i = '0;

  renaming_map_mp #(
    .ARCH_REG_WIDTH (AW),
    .PHYS_REG_WIDTH (PW),
    .NR_PORTS       (NP)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .rename_valid_i  (rename_valid_i),
    .rename_rd_i     (rename_rd_i),
    .rename_rs1_i    (rename_rs1_i),
    .rename_rs2_i    (rename_rs2_i),
    .rename_ready_o  (rename_ready_o),
    .issue_valid_o   (issue_valid_o),
    .issue_prd_o     (issue_prd_o),
    .issue_prs1_o    (issue_prs1_o),
    .issue_prs2_o    (issue_prs2_o),
    .issue_old_prd_o (issue_old_prd_o),
    .commit_valid_i  (commit_valid_i),
    .commit_ard_i    (commit_ard_i),
    .commit_prd_i    (commit_prd_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int prd;
    int prs1;
    int prs2;
    int old;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input int prd, input int prs1, input int prs2, input int old);
    exp_t e;
    e.prd = prd; e.prs1 = prs1; e.prs2 = prs2; e.old = old;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic set_ren(input int p, input int rd, input int rs1, input int rs2);
    rename_valid_i[p]          = 1'b1;
    rename_rd_i[p*AW +: AW]    = AW'(rd);
    rename_rs1_i[p*AW +: AW]   = AW'(rs1);
    rename_rs2_i[p*AW +: AW]   = AW'(rs2);
  endtask

  task automatic set_cmt(input int p, input int ard, input int prd);
    commit_valid_i[p]        = 1'b1;
    commit_ard_i[p*AW +: AW] = AW'(ard);
    commit_prd_i[p*PW +: PW] = PW'(prd);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    rename_valid_i = '0;
    commit_valid_i = '0;
    flush_i        = 1'b0;
  endtask

  task automatic mon_port(input int p);
    exp_t e;
    int   prd, prs1, prs2, old, qsz;
    prd  = int'(issue_prd_o[p*PW +: PW]);
    prs1 = int'(issue_prs1_o[p*PW +: PW]);
    prs2 = int'(issue_prs2_o[p*PW +: PW]);
    old  = int'(issue_old_prd_o[p*PW +: PW]);
    qsz  = (p == 0) ? q0.size() : q1.size();
    if (qsz == 0) begin
      check($sformatf("unexpected_issue_p%0d", p), int'(issue_valid_o[p]), 0);
    end else begin
      if (p == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      $display("t=%0t port%0d issue prd=%0d prs1=%0d prs2=%0d old=%0d", $time, p, prd, prs1, prs2, old);
      check($sformatf("prd_p%0d", p), prd, e.prd);
      check($sformatf("prs1_p%0d", p), prs1, e.prs1);
      check($sformatf("prs2_p%0d", p), prs2, e.prs2);
      check($sformatf("old_prd_p%0d", p), old, e.old);
    end
  endtask

  // Monitor: compare every presented issue entry against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int p = 0; p < NP; p++) begin
        if (issue_valid_o[p]) mon_port(p);
      end
    end
  end

  // Free-list order seen by the exhaustion phase: p3, p4, then p7 upwards.
  function automatic int ord(input int n);
    return (n < 2) ? n + 3 : n + 5;
  endfunction

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("reset_ready", int'(rename_ready_o), 1);
    check("reset_issue_valid", int'(issue_valid_o), 0);
    check("reset_issue_prd", int'(issue_prd_o), 0);
    check("reset_issue_prs1", int'(issue_prs1_o), 0);
    check("reset_issue_prs2", int'(issue_prs2_o), 0);
    check("reset_issue_old", int'(issue_old_prd_o), 0);

    // Single port: rd=4 then rd=5, each committed.
    set_ren(0, 4, 0, 0); push_exp(0, 1, 0, 0, 0); step();
    set_cmt(0, 4, 1); step();
    set_ren(0, 5, 0, 0); push_exp(0, 2, 0, 0, 0); step();
    set_cmt(0, 5, 2); step();

    // ADD ar3, ar4, ar5 three times, each committed before the next.
    set_ren(0, 3, 4, 5); push_exp(0, 3, 1, 2, 0); step();
    set_cmt(0, 3, 3); step();
    set_ren(0, 3, 4, 5); push_exp(0, 4, 1, 2, 3); step();
    set_cmt(0, 3, 4); step();
    set_ren(0, 3, 4, 5); push_exp(0, 3, 1, 2, 4); step();
    set_cmt(0, 3, 3); step();

    // Intra-group bypass on rd=3, then read back spec map[3].
    set_ren(0, 3, 0, 0); set_ren(1, 3, 3, 4);
    push_exp(0, 4, 0, 0, 3); push_exp(1, 5, 4, 1, 4); step();
    set_ren(0, 6, 3, 0); push_exp(0, 6, 5, 0, 0); step();
    set_cmt(0, 3, 4); set_cmt(1, 3, 5); step();
    set_cmt(0, 6, 6); step();

    // Exhaustion: 59 free, take 58 leaving only p63.
    for (int k = 0; k < 29; k++) begin
      set_ren(0, 7, 0, 0); set_ren(1, 8, 0, 0);
      push_exp(0, ord(2*k),     0, 0, (k == 0) ? 0 : ord(2*k - 2));
      push_exp(1, ord(2*k + 1), 0, 0, (k == 0) ? 0 : ord(2*k - 1));
      step();
    end
    set_ren(0, 9, 0, 0);
    #1 check("ready_one_free_one_need", int'(rename_ready_o), 1);
    set_ren(1, 10, 0, 0);
    #1 check("ready_one_free_two_need", int'(rename_ready_o), 0);
    set_cmt(0, 7, 3); set_cmt(1, 7, 7);
    #1 check("ready_no_free_bypass", int'(rename_ready_o), 0);
    step();
    set_ren(0, 9, 0, 0); set_ren(1, 10, 0, 0);
    #1 check("ready_after_free", int'(rename_ready_o), 1);
    push_exp(0, 3, 0, 0, 0); push_exp(1, 63, 0, 0, 0); step();
    set_ren(0, 0, 9, 10); push_exp(0, 0, 3, 63, 0); step();

    // Reset with an issue entry in flight.
    set_ren(0, 0, 9, 10); step();
    check("inflight_valid", int'(issue_valid_o), 1);
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_valid", int'(issue_valid_o), 0);
    check("async_reset_prs1", int'(issue_prs1_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1 check("post_reset_ready", int'(rename_ready_o), 1);

    // Flush after three uncommitted renames.
    set_ren(0, 4, 0, 0); push_exp(0, 1, 0, 0, 0); step();
    set_cmt(0, 4, 1); step();
    set_ren(0, 4, 4, 0); set_ren(1, 5, 0, 0);
    push_exp(0, 2, 1, 0, 1); push_exp(1, 3, 0, 0, 0); step();
    set_ren(0, 6, 4, 0); push_exp(0, 4, 2, 0, 0); step();
    flush_i = 1'b1; set_ren(0, 7, 0, 0);
    #1 check("ready_during_flush", int'(rename_ready_o), 0);
    step();
    set_ren(0, 7, 4, 5); set_ren(1, 6, 6, 0);
    push_exp(0, 2, 1, 0, 0); push_exp(1, 3, 0, 0, 0); step();
    set_ren(0, 8, 0, 0); push_exp(0, 4, 0, 0, 0); step();
    step();
    step();

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
